// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: run/pause/done controller for a cascaded chain of mod-10
// up/down digits behaving as one multi-digit BCD timer. A prescaler paces the
// count steps; carry/borrow ripples between digits; reaching the terminal
// count (all 9s going up, all 0s going down) raises a single-cycle done.
module bcd_timer_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  dir,
    input  logic                  load_en,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic [1:0]            state,
    output logic                  busy,
    output logic                  done
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    count_q, count_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            run_dir_q, run_dir_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [W-1:0]    stepped;
    logic            stepped_terminal;
    logic            start_terminal;
    logic            tick;

    // Digits above 9 in a loaded value are forced to 9 so count stays valid BCD.
    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    function automatic logic all_nines(input logic [W-1:0] v);
        logic r;
        r = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) begin
                r = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic all_zeros(input logic [W-1:0] v);
        return (v == '0);
    endfunction

    // A digit moves only while every lower digit is at 9 (the carry chain).
    function automatic logic [W-1:0] step_up(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // A digit moves only while every lower digit is at 0 (the borrow chain).
    function automatic logic [W-1:0] step_down(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick             = (presc_q == PRESC_LAST);
    assign stepped          = run_dir_q ? step_down(count_q) : step_up(count_q);
    assign stepped_terminal = run_dir_q ? all_zeros(stepped) : all_nines(stepped);
    assign start_terminal   = dir ? all_zeros(count_q) : all_nines(count_q);

    // Next-state decode: clear beats stop beats start beats load; counting otherwise.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        presc_d   = presc_q;
        run_dir_d = run_dir_q;
        done_d    = 1'b0;

        if (clear) begin
            count_d = '0;
            presc_d = '0;
            state_d = ST_IDLE;
        end else if (stop) begin
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end
        end else if (start && (state_q == ST_IDLE || state_q == ST_PAUSE)) begin
            run_dir_d = dir;
            if (start_terminal) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else if (load_en && state_q != ST_RUN) begin
            count_d = clamp_bcd(load_val);
            presc_d = '0;
            if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end else if (state_q == ST_RUN) begin
            if (tick) begin
                presc_d = '0;
                count_d = stepped;
                if (stepped_terminal) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        busy_d = (state_d == ST_RUN);
    end

    // State, count, prescaler and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            presc_q   <= '0;
            run_dir_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            run_dir_q <= run_dir_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign count = count_q;
    assign state = state_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: scoreboard bench for bcd_timer_ctrl. Each stimulus cycle
// advances an integer-valued reference model and queues the expected outputs;
// a monitor pops and compares them one step after every rising edge.
module tb_bcd_timer_ctrl;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;
    localparam int MAXV     = 9999;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic        dir = 1'b0;
    logic        load_en = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] count;
    logic [1:0]  state;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [15:0] count;
        logic [1:0]  state;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks   = 0;
    int failures = 0;

    // Reference model: count held as a plain decimal integer.
    int m_val;
    int m_state;
    int m_presc;
    bit m_dir;
    bit m_done;

    bcd_timer_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .dir(dir), .load_en(load_en), .load_val(load_val),
        .count(count), .state(state), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] toBcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int clampLoad(input logic [15:0] v);
        int r, w, nib;
        r = 0;
        w = 1;
        for (int i = 0; i < DIGITS; i++) begin
            nib = int'(v[4*i +: 4]);
            if (nib > 9) nib = 9;
            r = r + nib * w;
            w = w * 10;
        end
        return r;
    endfunction

    function automatic exp_t modelOutputs();
        exp_t e;
        e.count = toBcd(m_val);
        e.state = 2'(m_state);
        e.busy  = (m_state == 1);
        e.done  = m_done;
        return e;
    endfunction

    function automatic exp_t mkExp(input logic [15:0] c, input logic [1:0] s, input logic b, input logic d);
        exp_t e;
        e.count = c;
        e.state = s;
        e.busy  = b;
        e.done  = d;
        return e;
    endfunction

    task automatic modelReset();
        m_val   = 0;
        m_state = 0;
        m_presc = 0;
        m_dir   = 1'b0;
        m_done  = 1'b0;
    endtask

    task automatic modelEdge(input bit s, input bit sp, input bit c, input bit d,
                             input bit le, input logic [15:0] lv);
        m_done = 1'b0;
        if (c) begin
            m_val   = 0;
            m_presc = 0;
            m_state = 0;
        end else if (sp) begin
            if (m_state == 1) m_state = 2;
        end else if (s && (m_state == 0 || m_state == 2)) begin
            m_dir = d;
            if ((!d && m_val == MAXV) || (d && m_val == 0)) begin
                m_state = 3;
                m_done  = 1'b1;
            end else begin
                m_state = 1;
            end
        end else if (le && m_state != 1) begin
            m_val   = clampLoad(lv);
            m_presc = 0;
            if (m_state == 3) m_state = 0;
        end else if (m_state == 1) begin
            if (m_presc == PRESCALE - 1) begin
                m_presc = 0;
                if (m_dir) m_val = (m_val == 0) ? MAXV : m_val - 1;
                else       m_val = (m_val + 1) % (MAXV + 1);
                if ((!m_dir && m_val == MAXV) || (m_dir && m_val == 0)) begin
                    m_state = 3;
                    m_done  = 1'b1;
                end
            end else begin
                m_presc = m_presc + 1;
            end
        end
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input exp_t e);
        checkField({tag, ".count"}, 32'(count), 32'(e.count));
        checkField({tag, ".state"}, 32'(state), 32'(e.state));
        checkField({tag, ".busy"},  32'(busy),  32'(e.busy));
        checkField({tag, ".done"},  32'(done),  32'(e.done));
    endtask

    task automatic applyStimulus(input bit s, input bit sp, input bit c, input bit d,
                                 input bit le, input logic [15:0] lv);
        @(negedge clk);
        start    = s;
        stop     = sp;
        clear    = c;
        dir      = d;
        load_en  = le;
        load_val = lv;
        modelEdge(s, sp, c, d, le, lv);
        exp_q.push_back(modelOutputs());
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic checkNow(input string tag, input logic [15:0] c, input logic [1:0] s,
                            input logic b, input logic d);
        #2;
        checkOutput(tag, mkExp(c, s, b, d));
    endtask

    // Monitor: compare the oldest queued expectation once outputs have settled.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checkOutput("scoreboard", mon_e);
        end
    end

    initial begin
        bit s, sp, c, d, le;
        logic [15:0] lv;
        logic [15:0] near [8];

        near[0] = 16'h9998; near[1] = 16'h9990; near[2] = 16'h0001; near[3] = 16'h0010;
        near[4] = 16'h0000; near[5] = 16'h9999; near[6] = 16'h00A5; near[7] = 16'hFFFF;

        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset", mkExp(16'h0000, 2'd0, 1'b0, 1'b0));
        rst = 1'b0;

        // Two-digit carry going up.
        applyStimulus(0, 0, 0, 0, 1, 16'h0198);
        applyStimulus(1, 0, 0, 0, 0, 16'h0000);
        idle(4);
        checkNow("carry_one", 16'h0199, 2'd1, 1'b1, 1'b0);
        idle(4);
        checkNow("carry_two", 16'h0200, 2'd1, 1'b1, 1'b0);

        // Borrow through three digits going down.
        applyStimulus(0, 0, 1, 0, 0, 16'h0000);
        applyStimulus(0, 0, 0, 0, 1, 16'h1000);
        applyStimulus(1, 0, 0, 1, 0, 16'h0000);
        idle(4);
        checkNow("borrow", 16'h0999, 2'd1, 1'b1, 1'b0);

        // Count down into terminal zero; done pulses once; start in DONE ignored.
        applyStimulus(0, 0, 1, 0, 0, 16'h0000);
        applyStimulus(0, 0, 0, 0, 1, 16'h0002);
        applyStimulus(1, 0, 0, 1, 0, 16'h0000);
        idle(4);
        checkNow("down_one", 16'h0001, 2'd1, 1'b1, 1'b0);
        idle(4);
        checkNow("down_done", 16'h0000, 2'd3, 1'b0, 1'b1);
        idle(1);
        checkNow("done_drop", 16'h0000, 2'd3, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 1, 0, 16'h0000);
        checkNow("start_in_done", 16'h0000, 2'd3, 1'b0, 1'b0);

        // Pause with prescaler at 2, hold, then resume mid-interval.
        applyStimulus(0, 0, 1, 0, 0, 16'h0000);
        applyStimulus(1, 0, 0, 0, 0, 16'h0000);
        idle(2);
        applyStimulus(0, 1, 0, 0, 0, 16'h0000);
        idle(10);
        checkNow("paused", 16'h0000, 2'd2, 1'b0, 1'b0);
        applyStimulus(1, 0, 0, 0, 0, 16'h0000);
        idle(1);
        checkNow("resume_wait", 16'h0000, 2'd1, 1'b1, 1'b0);
        idle(1);
        checkNow("resume_step", 16'h0001, 2'd1, 1'b1, 1'b0);

        // Load clamping and immediate DONE on a terminal start.
        applyStimulus(0, 0, 1, 0, 0, 16'h0000);
        applyStimulus(0, 0, 0, 0, 1, 16'h00A5);
        checkNow("clamp", 16'h0095, 2'd0, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 0, 1, 16'h9999);
        applyStimulus(1, 0, 0, 0, 0, 16'h0000);
        checkNow("instant_done", 16'h9999, 2'd3, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a clock phase while running.
        applyStimulus(0, 0, 1, 0, 0, 16'h0000);
        applyStimulus(0, 0, 0, 0, 1, 16'h0037);
        applyStimulus(1, 0, 0, 0, 0, 16'h0000);
        idle(2);
        @(negedge clk);
        checkOutput("pre_reset", mkExp(16'h0037, 2'd1, 1'b1, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset", mkExp(16'h0000, 2'd0, 1'b0, 1'b0));
        modelReset();
        @(negedge clk);
        rst = 1'b0;

        // clear and start together: clear wins.
        applyStimulus(0, 0, 0, 0, 1, 16'h0042);
        applyStimulus(1, 0, 1, 0, 0, 16'h0000);
        checkNow("clear_start", 16'h0000, 2'd0, 1'b0, 1'b0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            c  = ($urandom_range(0, 99) < 2);
            sp = ($urandom_range(0, 99) < 4);
            s  = ($urandom_range(0, 99) < 8);
            le = ($urandom_range(0, 99) < 6);
            d  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) lv = near[$urandom_range(0, 7)];
            else                           lv = 16'($urandom);
            if (sp && m_state != 1) begin
                s  = 1'b0;
                le = 1'b0;
            end
            if (s && m_state == 3) le = 1'b0;
            applyStimulus(s, sp, c, d, le, lv);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_timer_ctrl.md
# bcd_timer_ctrl

Run/pause/done controller sequencing a cascaded chain of mod-10 up/down digits as one multi-digit BCD timer. It generates the per-digit step enable from a clock prescaler and propagates carry/borrow between digits. It detects the terminal count and raises a single-cycle done. It sits between front-panel control pulses (start/stop/clear/load) and the digit display path.

## Interface
- DIGITS, 4: number of cascaded BCD digits (>=1).
- PRESCALE, 1000: clk cycles per count step (>=2).

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request RUN (level sampled each edge).
- stop  in  1  request PAUSE.
- clear  in  1  zero the count and return to IDLE.
- dir  in  1  0 = count up, 1 = count down; latched when RUN is entered.
- load_en  in  1  load load_val into count.
- load_val  in  4*DIGITS  packed BCD, digit 0 in bits [3:0].
- count  out  4*DIGITS  current packed BCD value, registered.
- state  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 DONE.
- busy  out  1  high while state==RUN.
- done  out  1  one-cycle pulse on entry to DONE.

## Operation
- Reset values: count=0, state=IDLE, busy=0, done=0, prescaler=0, run_dir=0.
- Control priority per edge: clear > stop > start > load_en.
- clear, any state: count=0, prescaler=0, state -> IDLE.
- load_en, IDLE/PAUSE/DONE only (ignored in RUN):
  - count=load_val, each digit >9 clamped to 9.
  - prescaler=0; DONE -> IDLE.
- start, IDLE/PAUSE: latch run_dir=dir.
  - If count is already terminal for dir (up: all 9s; down: all 0s): state -> DONE, done=1, count unchanged.
  - Otherwise: state -> RUN.
  - start in RUN or DONE is ignored.
- stop in RUN: state -> PAUSE; prescaler holds its value (resume continues mid-interval). stop in other states is ignored.
- RUN:
  - Prescaler counts 0..PRESCALE-1 and wraps.
  - tick = (prescaler == PRESCALE-1).
  - On tick, count steps by one in run_dir.
- Up step: digit i increments if all lower digits are 9; 9 wraps to 0.
- Down step: digit i decrements if all lower digits are 0; 0 wraps to 9.
- Terminal: if the stepped value is terminal (up 9..9, down 0..0), on the same edge state -> DONE and done=1.
- DONE: count holds; exit only via clear or load_en.
- count is always valid BCD; no digit ever exceeds 9.

## Timing
- A start sampled on edge t enters RUN at t. With a fresh prescaler (0), the first step lands on edge t+PRESCALE and each later step every PRESCALE edges.
- A stop sampled on edge t leaves no step at t or after. If the prescaler reads p at stop, a later resume steps after PRESCALE-1-p further edges plus one.
- stop and tick on the same edge: stop wins, no step, prescaler holds.
- done is high exactly one cycle: the cycle after the edge that writes the terminal count. busy falls on that same edge.
- clear/load/start responses take effect on the sampling edge; outputs update one edge later (registered).
- rst mid-RUN immediately forces all reset values, regardless of clk.

## Test plan
- PRESCALE=4, DIGITS=4. Load 0x0198, start with dir=0 -> count 0x0199 at 4 edges after start, 0x0200 at 8 edges (two-digit carry).
- dir=1, load 0x1000, start -> 0x0999 after 4 edges (borrow through three digits); busy=1 throughout.
- dir=1, load 0x0002, start -> 0x0001, then 0x0000 with done=1 for exactly one cycle, state=3, busy=0. A further start leaves state=3 and count=0x0000.
- Run up from 0; assert stop when prescaler=2 -> state=2, count frozen 10 cycles. Start again -> next step after 2 edges.
- load_val=0x00A5 -> count=0x0095. Load 0x9999, start dir=0 -> immediate DONE, done pulse, no count change.
- Assert rst while RUN at count 0x0037 -> count=0, state=0, busy=0, done=0 asynchronously. clear+start on the same edge -> IDLE, count=0.
